// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants, state encoding and the XNOR recurrence
//               s[k] = ~(s[k-8] ^ s[k-7]) for the 8-bit game LFSR stream.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam int TAP_A  = 7;
  localparam int TAP_B  = 6;

  // All-ones is the XNOR fixed point; a register stuck there never moves.
  localparam logic [LFSR_W-1:0] LOCKUP_STATE = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next stream bit given the last LFSR_W bits (bit 0 = newest).
  function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_A] ^ s[TAP_B]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_ref_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_ref_gen
// Description : Loadable local copy of the game LFSR used to flywheel the
//               expected stream once the checker is locked.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_ref_gen
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  output logic [LFSR_W-1:0] gen
);

  logic [LFSR_W-1:0] gen_q;
  logic [LFSR_W-1:0] gen_d;

  // Load wins over advance so the lock cycle seeds from the received history.
  always_comb begin
    gen_d = gen_q;
    if (load) begin
      gen_d = load_val;
    end else if (adv) begin
      gen_d = {gen_q[LFSR_W-2:0], lfsr_next_bit(gen_q)};
    end
  end

  // Generator state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q <= '0;
    end else begin
      gen_q <= gen_d;
    end
  end

  assign gen = gen_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Self-synchronising serial checker for the 8-bit XNOR LFSR
//               stream. Hunts, syncs, locks, flywheels and counts errors;
//               drops lock when errors within a window reach LOSS_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int WINDOW   = 64,
  parameter int LOSS_ERR = 8,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int WB_W  = $clog2(WINDOW + 1);
  localparam int WE_W  = $clog2(LOSS_ERR + 1);

  state_e             state_q,     state_d;
  logic [LFSR_W-1:0]  hist_q,      hist_d;
  logic [2:0]         fill_q,      fill_d;
  logic [RUN_W-1:0]   run_q,       run_d;
  logic [WB_W-1:0]    win_bits_q,  win_bits_d;
  logic [WE_W-1:0]    win_err_q,   win_err_d;
  logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic               locked_q,    locked_d;

  logic               gen_load;
  logic               gen_adv;
  logic [LFSR_W-1:0]  gen;
  logic [LFSR_W-1:0]  hist_shift;
  logic               pred;
  logic               expected;

  lfsr_ref_gen u_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (gen_load),
    .load_val (hist_d),
    .adv      (gen_adv),
    .gen      (gen)
  );

  assign hist_shift = {hist_q[LFSR_W-2:0], in_bit};
  assign pred       = lfsr_next_bit(hist_q);
  assign expected   = lfsr_next_bit(gen);

  // Next-state, counters and outputs; nothing moves without in_valid except clr_err.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_bits_d  = win_bits_q;
    win_err_d   = win_err_q;
    err_cnt_d   = clr_err ? '0 : err_cnt_q;
    err_pulse_d = 1'b0;
    gen_load    = 1'b0;
    gen_adv     = 1'b0;

    if (in_valid) begin
      hist_d = hist_shift;
      case (state_q)
        HUNT: begin
          if (fill_q == 3'd7) begin
            fill_d  = '0;
            run_d   = '0;
            state_d = SYNC;
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end

        SYNC: begin
          run_d = (in_bit == pred) ? run_q + 1'b1 : '0;
          // A stuck-at-1 line would otherwise predict itself perfectly.
          if (hist_shift == LOCKUP_STATE) begin
            run_d = '0;
          end
          if (run_d == RUN_W'(LOCK_CNT)) begin
            run_d    = '0;
            state_d  = LOCKED;
            gen_load = 1'b1;
          end
        end

        LOCKED: begin
          gen_adv    = 1'b1;
          win_bits_d = win_bits_q + 1'b1;
          if (in_bit != expected) begin
            err_pulse_d = 1'b1;
            win_err_d   = win_err_q + 1'b1;
            if (err_cnt_d != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_d + 1'b1;
            end
          end
          // Loss of lock is checked before the window rollover on the same bit.
          if (win_err_d == WE_W'(LOSS_ERR)) begin
            state_d    = HUNT;
            fill_d     = '0;
            run_d      = '0;
            win_bits_d = '0;
            win_err_d  = '0;
          end else if (win_bits_d == WB_W'(WINDOW)) begin
            win_bits_d = '0;
            win_err_d  = '0;
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      hist_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_bits_q  <= win_bits_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_checker
// Description : Directed self-checking bench for lfsr_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        clr_err;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  int          total;
  int          bad;
  logic [7:0]  g;

  lfsr_checker #(
    .LOCK_CNT (16),
    .WINDOW   (64),
    .LOSS_ERR (8),
    .ERR_W    (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one edge, then sample 1 time unit after it.
  task automatic tick(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr_err  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  // Send the next bit of the reference stream, optionally inverted.
  task automatic send_bit(input logic flip, input logic c);
    logic nb;
    nb = ~(g[7] ^ g[6]);
    g  = {g[6:0], nb};
    tick(1'b1, nb ^ flip, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g   = 8'h7F;
  endtask

  task automatic relock();
    do_reset();
    repeat (24) send_bit(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (locked !== 1'b0)   begin bad++; $display("FAIL reset_locked got=%0d want=0", locked); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0d want=0", err_pulse); end
    total++; if (err_cnt !== 16'd0)  begin bad++; $display("FAIL reset_errcnt got=%0d want=0", err_cnt); end
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
  endtask

  task automatic test_clean_lock();
    int pulses;
    do_reset();
    repeat (23) send_bit(1'b0, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%0d want=0", locked); end
    total++; if (state !== 2'd1)  begin bad++; $display("FAIL lock_sync_state got=%0d want=1", state); end
    send_bit(1'b0, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_at24 got=%0d want=1", locked); end
    total++; if (state !== 2'd2)  begin bad++; $display("FAIL lock_state got=%0d want=2", state); end
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      send_bit(1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 0)      begin bad++; $display("FAIL clean_pulses got=%0d want=0", pulses); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clean_errcnt got=%0d want=0", err_cnt); end
    total++; if (locked !== 1'b1)  begin bad++; $display("FAIL clean_locked got=%0d want=1", locked); end
  endtask

  task automatic test_single_flip();
    int pulses;
    relock();
    send_bit(1'b1, 1'b0);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL flip_pulse got=%0d want=1", err_pulse); end
    total++; if (err_cnt !== 16'd1)  begin bad++; $display("FAIL flip_errcnt got=%0d want=1", err_cnt); end
    total++; if (locked !== 1'b1)    begin bad++; $display("FAIL flip_locked got=%0d want=1", locked); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 0)       begin bad++; $display("FAIL flywheel_pulses got=%0d want=0", pulses); end
    total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL flywheel_errcnt got=%0d want=1", err_cnt); end
  endtask

  task automatic test_loss();
    relock();
    repeat (7) send_bit(1'b1, 1'b0);
    total++; if (locked !== 1'b1)   begin bad++; $display("FAIL loss_7_locked got=%0d want=1", locked); end
    total++; if (err_cnt !== 16'd7) begin bad++; $display("FAIL loss_7_errcnt got=%0d want=7", err_cnt); end
    send_bit(1'b1, 1'b0);
    total++; if (locked !== 1'b0)    begin bad++; $display("FAIL loss_8_locked got=%0d want=0", locked); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL loss_8_pulse got=%0d want=1", err_pulse); end
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL loss_8_state got=%0d want=0", state); end
    total++; if (err_cnt !== 16'd8)  begin bad++; $display("FAIL loss_8_errcnt got=%0d want=8", err_cnt); end
    repeat (23) send_bit(1'b0, 1'b0);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL relock_early got=%0d want=0", locked); end
    send_bit(1'b0, 1'b0);
    total++; if (locked !== 1'b1)   begin bad++; $display("FAIL relock_24 got=%0d want=1", locked); end
    total++; if (err_cnt !== 16'd8) begin bad++; $display("FAIL relock_errcnt got=%0d want=8", err_cnt); end
  endtask

  task automatic test_window();
    relock();
    repeat (7) send_bit(1'b1, 1'b0);
    repeat (57) send_bit(1'b0, 1'b0);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL win_roll_locked got=%0d want=1", locked); end
    repeat (7) send_bit(1'b1, 1'b0);
    total++; if (locked !== 1'b1)    begin bad++; $display("FAIL win2_7_locked got=%0d want=1", locked); end
    total++; if (err_cnt !== 16'd14) begin bad++; $display("FAIL win2_7_errcnt got=%0d want=14", err_cnt); end
    send_bit(1'b1, 1'b0);
    total++; if (locked !== 1'b0)    begin bad++; $display("FAIL win2_8_locked got=%0d want=0", locked); end
    total++; if (err_cnt !== 16'd15) begin bad++; $display("FAIL win2_8_errcnt got=%0d want=15", err_cnt); end
  endtask

  task automatic test_stuck_one();
    int seen_lock;
    do_reset();
    seen_lock = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (locked === 1'b1) seen_lock++;
    end
    total++; if (seen_lock != 0)    begin bad++; $display("FAIL stuck_locked got=%0d want=0", seen_lock); end
    total++; if (state !== 2'd1)    begin bad++; $display("FAIL stuck_state got=%0d want=1", state); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL stuck_errcnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_gaps();
    int nvalid;
    int early;
    int pulses;
    int cycles;
    do_reset();
    nvalid = 0;
    early  = 0;
    cycles = 0;
    while (nvalid < 24 && cycles < 1000) begin
      cycles++;
      if ($urandom_range(0, 1) == 1) begin
        send_bit(1'b0, 1'b0);
        nvalid++;
      end else begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (nvalid < 24 && locked === 1'b1) early++;
    end
    total++; if (nvalid != 24)    begin bad++; $display("FAIL gaps_budget got=%0d want=24", nvalid); end
    total++; if (early != 0)      begin bad++; $display("FAIL gaps_early got=%0d want=0", early); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL gaps_locked got=%0d want=1", locked); end
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    total++; if (state !== 2'd2)  begin bad++; $display("FAIL gaps_idle_state got=%0d want=2", state); end
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) send_bit(1'b0, 1'b0);
      else tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 0)       begin bad++; $display("FAIL gaps_pulses got=%0d want=0", pulses); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL gaps_errcnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_reset_midlock();
    relock();
    repeat (5) send_bit(1'b1, 1'b0);
    total++; if (err_cnt !== 16'd5) begin bad++; $display("FAIL mid_errcnt got=%0d want=5", err_cnt); end
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    total++; if (locked !== 1'b0)    begin bad++; $display("FAIL mid_rst_locked got=%0d want=0", locked); end
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_pulse got=%0d want=0", err_pulse); end
    total++; if (err_cnt !== 16'd0)  begin bad++; $display("FAIL mid_rst_errcnt got=%0d want=0", err_cnt); end
    total++; if (state !== 2'd0)     begin bad++; $display("FAIL mid_rst_state got=%0d want=0", state); end
  endtask

  task automatic test_clr_err();
    relock();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL clr_pre got=%0d want=2", err_cnt); end
    send_bit(1'b1, 1'b1);
    total++; if (err_cnt !== 16'd1)  begin bad++; $display("FAIL clr_with_err got=%0d want=1", err_cnt); end
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_with_err_pulse got=%0d want=1", err_pulse); end
    tick(1'b0, 1'b0, 1'b1);
    total++; if (err_cnt !== 16'd0)  begin bad++; $display("FAIL clr_idle got=%0d want=0", err_cnt); end
    total++; if (locked !== 1'b1)    begin bad++; $display("FAIL clr_locked got=%0d want=1", locked); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clr_err  = 1'b0;
    g        = 8'h7F;
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_loss();
    test_window();
    test_stuck_one();
    test_gaps();
    test_reset_midlock();
    test_clr_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
